// File: rtl/ntt_bitrev_reorder_ctrl.sv
// Ping-pong frame buffer that re-emits N-point NTT frames in bit-reversed order.
// Optional NTT_BITREV_BYPASS_EN adds a per-frame bypass input for natural-order drain.

// state          | meaning
// BANK_EMPTY     | bank holds no frame, writable
// BANK_FILLING   | bank partially written
// BANK_FULL      | bank holds a complete frame, nothing read yet
// BANK_DRAINING  | bank partially read out
module ntt_bitrev_reorder_ctrl #(
   parameter int WIDTH = 8,
   parameter int LOG_N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
`ifdef NTT_BITREV_BYPASS_EN
   ,
   input  logic             bypass
`endif
);

   localparam int N = 1 << LOG_N;
   localparam logic [LOG_N-1:0] CNT_MAX = LOG_N'(N - 1);

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_state_t;

   bank_state_t      bank_q [2];
   bank_state_t      bank_d [2];
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [LOG_N-1:0] wr_cnt_q, wr_cnt_d;
   logic [LOG_N-1:0] rd_cnt_q, rd_cnt_d;
   logic [WIDTH-1:0] mem [2][N];
   logic             wr_en, rd_en;
   logic             out_valid_d;
   logic [LOG_N-1:0] rd_addr_d;
   logic [WIDTH-1:0] rd_data_d;
`ifdef NTT_BITREV_BYPASS_EN
   logic             byp_q [2];
   logic             byp_d [2];
`endif

   function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
      logic [LOG_N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
      return r;
   endfunction

   assign in_ready  = (bank_q[wr_bank_q] == BANK_EMPTY) || (bank_q[wr_bank_q] == BANK_FILLING);
   assign out_valid = (bank_q[rd_bank_q] == BANK_FULL) || (bank_q[rd_bank_q] == BANK_DRAINING);
   assign busy      = (bank_q[0] != BANK_EMPTY) || (bank_q[1] != BANK_EMPTY);
   assign wr_en     = in_valid & in_ready;
   assign rd_en     = out_valid & out_ready;

   always_comb begin
      bank_d[0] = bank_q[0];
      bank_d[1] = bank_q[1];
      wr_bank_d = wr_bank_q;
      wr_cnt_d  = wr_cnt_q;
      rd_bank_d = rd_bank_q;
      rd_cnt_d  = rd_cnt_q;
`ifdef NTT_BITREV_BYPASS_EN
      byp_d[0]  = byp_q[0];
      byp_d[1]  = byp_q[1];
`endif

      // Read and write always target different banks, so both updates can apply.
      if (rd_en) begin
         if (rd_cnt_q == CNT_MAX) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_cnt_d          = '0;
            rd_bank_d         = ~rd_bank_q;
         end else begin
            bank_d[rd_bank_q] = BANK_DRAINING;
            rd_cnt_d          = rd_cnt_q + 1'b1;
         end
      end

      if (wr_en) begin
`ifdef NTT_BITREV_BYPASS_EN
         if (wr_cnt_q == '0) byp_d[wr_bank_q] = bypass;
`endif
         if (wr_cnt_q == CNT_MAX) begin
            bank_d[wr_bank_q] = BANK_FULL;
            wr_cnt_d          = '0;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            bank_d[wr_bank_q] = BANK_FILLING;
            wr_cnt_d          = wr_cnt_q + 1'b1;
         end
      end

      out_valid_d = (bank_d[rd_bank_d] == BANK_FULL) || (bank_d[rd_bank_d] == BANK_DRAINING);
`ifdef NTT_BITREV_BYPASS_EN
      rd_addr_d   = byp_d[rd_bank_d] ? rd_cnt_d : bitrev(rd_cnt_d);
`else
      rd_addr_d   = bitrev(rd_cnt_d);
`endif

      // Forward the word being written this edge in case it is the next read target.
      rd_data_d = mem[rd_bank_d][rd_addr_d];
      if (wr_en && (wr_bank_q == rd_bank_d) && (wr_cnt_q == rd_addr_d)) rd_data_d = in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q[0] <= BANK_EMPTY;
         bank_q[1] <= BANK_EMPTY;
         wr_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_bank_q <= 1'b0;
         rd_cnt_q  <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
`ifdef NTT_BITREV_BYPASS_EN
         byp_q[0]  <= 1'b0;
         byp_q[1]  <= 1'b0;
`endif
      end else begin
         bank_q[0] <= bank_d[0];
         bank_q[1] <= bank_d[1];
         wr_bank_q <= wr_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_bank_q <= rd_bank_d;
         rd_cnt_q  <= rd_cnt_d;
         out_data  <= rd_data_d;
         out_last  <= out_valid_d && (rd_cnt_d == CNT_MAX);
`ifdef NTT_BITREV_BYPASS_EN
         byp_q[0]  <= byp_d[0];
         byp_q[1]  <= byp_d[1];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem[wr_bank_q][wr_cnt_q] <= in_data;
   end

endmodule

// File: tb/tb_ntt_bitrev_reorder_ctrl.sv
// Randomized and directed bench for ntt_bitrev_reorder_ctrl against a frame-level queue model.
// Define NTT_BITREV_BYPASS_EN to also exercise the bypass port.
module tb_ntt_bitrev_reorder_ctrl;

   localparam int WIDTH = 8;
   localparam int LOG_N = 3;
   localparam int N     = 1 << LOG_N;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             busy;
   logic             bypass;

   int n_chk  = 0;
   int n_fail = 0;

   logic [WIDTH-1:0] exp_q [$];
   logic [WIDTH-1:0] part [N];
   int               part_cnt = 0;
   bit               part_byp = 1'b0;
   int               n_acc = 0;

   ntt_bitrev_reorder_ctrl #(.WIDTH(WIDTH), .LOG_N(LOG_N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
`ifdef NTT_BITREV_BYPASS_EN
      ,
      .bypass    (bypass)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int rev(input int i);
      int r = 0;
      for (int b = 0; b < LOG_N; b++)
         if (((i >> b) & 1) != 0) r += 1 << (LOG_N - 1 - b);
      return r;
   endfunction

   // One clock: check outputs against the model, drive inputs, advance the model.
   task automatic step(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit byp);
      int occ;
      bit exp_rdy;
      @(negedge clk);
      occ     = (exp_q.size() + N - 1) / N;
      exp_rdy = (occ < 2);
      check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
      check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check_eq("busy", 32'(busy), 32'((exp_q.size() > 0) || (part_cnt > 0)));
      if (exp_q.size() > 0) begin
         check_eq("out_data", 32'(out_data), 32'(exp_q[0]));
         check_eq("out_last", 32'(out_last), 32'((exp_q.size() % N) == 1));
      end else begin
         check_eq("out_last_idle", 32'(out_last), 32'(0));
      end
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      bypass    = byp;
      if (ordy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (iv && exp_rdy) begin
         if (part_cnt == 0) begin
`ifdef NTT_BITREV_BYPASS_EN
            part_byp = byp;
`else
            part_byp = 1'b0;
`endif
         end
         part[part_cnt] = d;
         part_cnt++;
         n_acc++;
         if (part_cnt == N) begin
            for (int i = 0; i < N; i++) exp_q.push_back(part_byp ? part[i] : part[rev(i)]);
            part_cnt = 0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bypass    = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      part_cnt = 0;
      check_eq("rst_out_valid", 32'(out_valid), 32'(0));
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_in_ready", 32'(in_ready), 32'(1));
      check_eq("rst_out_last", 32'(out_last), 32'(0));
      check_eq("rst_out_data", 32'(out_data), 32'(0));
   endtask

   task automatic drain(input int cycles);
      repeat (cycles) step(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      int start;
      int guard;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      bypass    = 1'b0;
      do_reset();

      // single frame, latency and ordering
      for (int k = 0; k < N; k++) step(1'b1, WIDTH'(k), 1'b1, 1'b0);
      drain(12);

      // three back-to-back frames
      for (int k = 0; k < 3 * N; k++) step(1'b1, WIDTH'(k), 1'b1, 1'b0);
      drain(12);

      // backpressure with both banks full, then release while still offering input
      for (int k = 0; k < 2 * N; k++) step(1'b1, WIDTH'(k), 1'b0, 1'b0);
      repeat (4) step(1'b1, 8'hAA, 1'b0, 1'b0);
      for (int k = 0; k < 2 * N; k++) step(1'b1, WIDTH'(8'h30 + k), 1'b1, 1'b0);
      drain(3 * N);

      // reset mid-fill and mid-drain
      for (int k = 0; k < N; k++) step(1'b1, WIDTH'(8'h40 + k), 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b1, WIDTH'(8'h50 + k), k < 3, 1'b0);
      do_reset();
      for (int k = 0; k < N; k++) step(1'b1, WIDTH'(8'h10 + k), 1'b1, 1'b0);
      drain(12);

      // random valid/ready over 50 frames
      start = n_acc;
      guard = 0;
      while ((n_acc - start) < 50 * N && guard < 8000) begin
         step(1'($urandom_range(0, 1)), WIDTH'($urandom), $urandom_range(0, 3) != 0, 1'b0);
         guard++;
      end
      check_eq("rand_inputs_accepted", 32'(n_acc - start), 32'(50 * N));
      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         step(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
         guard++;
      end
      check_eq("rand_drained", 32'(exp_q.size()), 32'(0));
      drain(2);

`ifdef NTT_BITREV_BYPASS_EN
      // bypass sampled only on a frame's first element
      for (int k = 0; k < N; k++) step(1'b1, WIDTH'(k), 1'b1, k == 0);
      for (int k = 0; k < N; k++) step(1'b1, WIDTH'(N + k), 1'b1, k != 0);
      drain(2 * N + 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
